fetch_queue: RTL and testbench

Instruction queue between the fetch stage and decode in the RV32I core. It captures each fetched {PC, instruction} pair under a valid/ready handshake and holds up to DEPTH entries in order. It presents the oldest entry to decode, which keeps fetch running through short decode stalls. A single-cycle flush discards all queued entries on a branch or jump redirect.

---
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry in-order buffer of {pc, instr, misaligned}
// with valid/ready on both sides and a single-cycle flush for redirects.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_misaligned,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   instr_mem[DEPTH];
  logic          mis_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign in_ready  = (count_q != CW'(DEPTH)) & ~flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    count_next = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Head fields are forced to a harmless NOP when empty so decode never sees stale storage.
  always_comb begin
    out_pc         = '0;
    out_instr      = NOP_INSTR;
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc         = pc_mem[rd_ptr];
      out_instr      = instr_mem[rd_ptr];
      out_misaligned = mis_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
      mis_mem[wr_ptr]   <= (in_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every cycle,
// plus directed literal expectations.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misaligned;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t model_q[$];

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_misaligned(out_misaligned), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue with the handshake rules applied at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit do_push, do_pop;
      entry_t e;
      do_push = in_valid && !flush && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() > 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          e.pc    = in_pc;
          e.instr = in_instr;
          model_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] epc, einstr;
    epc    = (model_q.size() > 0) ? model_q[0].pc    : 32'h0;
    einstr = (model_q.size() > 0) ? model_q[0].instr : NOP;
    chk("m_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    chk("m_out_pc", out_pc, epc);
    chk("m_out_instr", out_instr, einstr);
    chk("m_out_mis", 32'(out_misaligned), 32'(epc[1:0] != 2'b00));
    chk("m_count", 32'(count), 32'(model_q.size()));
    chk("m_in_ready", 32'(in_ready), 32'((model_q.size() < DEPTH) && !flush));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;

    // Reset and empty
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h00000013);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'hA0 + 32'(i);
      tick();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h10; in_instr = 32'hA4;
    tick();
    chk("fifth_refused", 32'(count), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(4 * i));
      chk("drain_instr", out_instr, 32'hA0 + 32'(i));
      tick();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Streaming across pointer wrap
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc = 32'h100 + 32'(4 * i); in_instr = 32'h1000 + 32'(i);
      tick();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc", out_pc, 32'h100 + 32'(4 * i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_drained", 32'(count), 32'd0);

    // Full with simultaneous pop: no full-bypass
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc = 32'h400 + 32'(4 * i); in_instr = 32'h2000 + 32'(i);
      tick();
    end
    in_pc = 32'h410; in_instr = 32'h2004; out_ready = 1'b1;
    tick();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_head", out_pc, 32'h404);
    tick();
    chk("pushpop_count", 32'(count), 32'd3);
    chk("pushpop_head", out_pc, 32'h408);
    in_valid = 1'b0; out_ready = 1'b0;

    // Flush with a concurrent push attempt
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'h3000;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    in_pc = 32'h300; in_instr = 32'h3001;
    tick();
    in_valid = 1'b0;
    chk("after_flush_pc", out_pc, 32'h300);
    chk("after_flush_instr", out_instr, 32'h3001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Misaligned head, then asynchronous reset mid-cycle
    in_valid = 1'b1; in_pc = 32'h102; in_instr = 32'h4000;
    tick();
    chk("mis_flag", 32'(out_misaligned), 32'd1);
    chk("mis_pc", out_pc, 32'h102);
    in_pc = 32'h104; in_instr = 32'h4001;
    tick();
    in_valid = 1'b0;
    chk("pre_arst_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_instr", out_instr, NOP);
    chk("arst_mis", 32'(out_misaligned), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
